muu_seq: RTL
============

# muu_seq

Multi-cycle sequencer for the multiply/divide unit. Accepts one MUU operation at a time from the execute stage and owns the architectural HI/LO registers. Runs signed multiply and divide iteratively at one bit per cycle, and services MFHI/MFLO with register reads. The pipeline stalls on `ready`; completion is signalled by a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32, operand/result width; HI:LO is 2*WIDTH
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  operation request; accepted only when `ready`=1
- `op`  in  4  0000 MUL, 0001 MULT, 0010 MADD, 0011 DIV, 0101 MFHI, 0110 MFLO; other codes are no-ops
- `rs`, `rt`  in  WIDTH  signed operands, sampled on accept
- `ready`  out  1  high only in IDLE
- `busy`  out  1  high in ITER and FIN
- `done`  out  1  one-cycle completion pulse
- `out`  out  WIDTH  result register; holds its value between writes
- `div_zero`  out  1  one-cycle pulse, DIV with `rt`=0
- `hi`, `lo`  out  WIDTH  architectural HI/LO, for debug/forwarding

## Operation
- States:
  - IDLE: accept on `start`.
  - ITER: 32 step cycles, counter 0..31.
  - FIN: sign fix-up and writeback, `done`=1.
  - Then back to IDLE.
- Accept in IDLE:
  - MUL, MULT, MADD, DIV with `rt`!=0: latch `|rs|`, `|rt|` and result sign, then go to ITER.
  - MFHI, MFLO, no-op codes: stay in IDLE with a single-cycle response.
- ITER, multiply: shift-add on the 64-bit magnitude product.
- ITER, divide: restoring division producing a 32-bit magnitude quotient and remainder.
- FIN writeback (negate where the sign requires):
  - MUL: `out` = low 32 bits of the signed product; HI/LO unchanged.
  - MULT: HI:LO = 64-bit signed product; `out` unchanged.
  - MADD: HI:LO = HI:LO + signed product, modulo 2^64; `out` unchanged.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of `rs`; `out` unchanged.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIV with `rt`=0:
  - No iteration; `div_zero` and `done` pulse the cycle after accept.
  - HI/LO and `out` unchanged.
- MFHI/MFLO: `out` takes HI/LO at the accept edge; `done` is high the following cycle.
- No-op codes: `done` pulses the following cycle; no other state changes.
- `start` while not `ready` is ignored. The requester holds `start`/`op`/operands until it sees `ready`.

## Timing
- Reset (`reset_n`=0 at an edge):
  - State IDLE, counter 0.
  - HI=LO=`out`=0; `done`=`div_zero`=0; `ready`=1, `busy`=0.
  - Applies mid-operation: the in-flight result is discarded with no writeback.
- MUL/MULT/MADD/DIV latency:
  - Accept at edge E0.
  - ITER during cycles E0..E32.
  - FIN during cycle E32..E33: `done`=1, `busy`=1.
  - Results visible on `out`/`hi`/`lo` after E33, when `ready` returns to 1.
- MFHI/MFLO, no-op, DIV-by-zero: accept at E0, `done` during E0..E1, `ready` stays 1.
  - Back-to-back accepts are legal, one per cycle.
- A `start` in the cycle after FIN is accepted normally.
- MFHI/MFLO is never accepted during ITER or FIN. The pipeline stall comes from `ready`, so MFHI/MFLO always observe a completed HI/LO.
- Accept is fixed at the `ready` edge: `start` and `reset_n` are never both acted on in one edge; reset wins.

## Structure
- Package `muu_pkg` holds:
  - op code localparams (`OP_MUL`, `OP_MULT`, `OP_MADD`, `OP_DIV`, `OP_MFHI`, `OP_MFLO`)
  - state encoding (IDLE/ITER/FIN)
  - `MUU_ITERS`=32
- Sub-module `muu_iter_core`: the one-bit-per-cycle shift-add / restoring-divide step datapath.
  - Combinational next-value logic plus the accumulator/quotient registers.
  - `muu_seq` keeps the FSM, counter, sign handling, HI/LO and `out`.

## Test plan
- MUL, rs=7, rt=0xFFFFFFFE:
  - `done` 33 cycles after accept; `out`=0xFFFFFFF2.
  - HI/LO unchanged.
- MULT, rs=0x704D0054, rt=0x400B000C, then MFHI, MFLO:
  - `out` holds 0xFFFFFFF2 through the MULT.
  - HI=0x1C181369, LO=0x473803F0.
- Repeat with MADD on the same operands, then MFHI/MFLO:
  - `out` holds 0x473803F0 through the MADD.
  - Then HI=0x383026D2, LO=0x8E7007E0.
- DIV, rs=7, rt=0xFFFFFFFE:
  - LO=0xFFFFFFFD, HI=1.
  - DIV rs=5, rt=0: `div_zero`=1 and `done`=1 the next cycle; HI/LO unchanged; no `busy`.
- MFHI issued mid-MULT:
  - Not accepted until `ready` rises.
  - Then returns the new HI.
- `reset_n` low at ITER cycle 10:
  - Next cycle: IDLE, HI=LO=`out`=0, no `done`.

Source files
------------

// File: rtl/muu_pkg.sv
// Shared definitions for the multiply/divide unit sequencer: op codes,
// FSM state encoding, iteration count and op classification helper.
package muu_pkg;

  localparam int MUU_ITERS = 32;

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_MULT = 4'b0001;
  localparam logic [3:0] OP_MADD = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MFHI = 4'b0101;
  localparam logic [3:0] OP_MFLO = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } muu_state_t;

  // True for the ops that run through the iterative datapath
  // (division by zero is filtered separately by the sequencer).
  function automatic logic is_iter_op(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_MULT) ||
           (code == OP_MADD) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/muu_iter_core.sv
// One-bit-per-cycle datapath shared by multiply and divide.
// acc holds {upper, lower} halves:
//   multiply: lower starts as the multiplier, upper accumulates partial sums;
//             after WIDTH steps acc is the unsigned 2*WIDTH product.
//   divide:   lower starts as the dividend; each step shifts left and does a
//             restoring subtract, so lower ends as quotient, upper as remainder.
module muu_iter_core
  import muu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   init_lo,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               div_mode_reg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_upper;
  logic [WIDTH:0]     div_diff;

  // Next-step value for either shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    // Partial remainder after the left shift; one extra bit so the trial
    // subtraction's sign bit is meaningful.
    div_upper = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_upper - {1'b0, opnd_reg};
    if (div_mode_reg) begin
      if (div_diff[WIDTH]) begin
        acc_next = {div_upper[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // Load operands on accept, then advance one bit per step cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg      <= '0;
      opnd_reg     <= '0;
      div_mode_reg <= 1'b0;
    end else if (load) begin
      acc_reg      <= {{WIDTH{1'b0}}, init_lo};
      opnd_reg     <= operand;
      div_mode_reg <= div_mode;
    end else if (step) begin
      acc_reg      <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/muu_seq.sv
// Multi-cycle multiply/divide sequencer. Owns HI/LO, runs signed
// MUL/MULT/MADD/DIV on magnitudes through muu_iter_core, applies the sign
// fix-up in FIN and services MFHI/MFLO and no-ops with a one-cycle response.
module muu_seq
  import muu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MUU_ITERS);

  muu_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [3:0]         op_reg;
  logic               neg_prod_reg;
  logic               neg_rem_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               done_reg;
  logic               div_zero_reg;
  logic               ready_reg;
  logic               busy_reg;

  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic               is_div;
  logic               rt_zero;
  logic               go_iter;
  logic               core_load;
  logic               core_step;
  logic [2*WIDTH-1:0] core_acc;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;

  // Operand magnitudes, accept decode and signed results of the finished run.
  always_comb begin
    rs_mag      = rs[WIDTH-1] ? -rs : rs;
    rt_mag      = rt[WIDTH-1] ? -rt : rt;
    is_div      = (op == OP_DIV);
    rt_zero     = (rt == '0);
    go_iter     = is_iter_op(op) && !(is_div && rt_zero);
    core_load   = (state_reg == ST_IDLE) && start && go_iter;
    core_step   = (state_reg == ST_ITER);
    prod_signed = neg_prod_reg ? -core_acc : core_acc;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    quot_signed = neg_prod_reg ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    rem_signed  = neg_rem_reg ? -core_acc[2*WIDTH-1:WIDTH]
                              : core_acc[2*WIDTH-1:WIDTH];
  end

  muu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (core_load),
    .step     (core_step),
    .div_mode (is_div),
    .init_lo  (is_div ? rs_mag : rt_mag),
    .operand  (is_div ? rt_mag : rs_mag),
    .acc      (core_acc)
  );

  // Sequencer FSM with registered status outputs and HI/LO/out writeback.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_MUL;
      neg_prod_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      out_reg      <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg       <= op;
            neg_prod_reg <= rs[WIDTH-1] ^ rt[WIDTH-1];
            neg_rem_reg  <= rs[WIDTH-1];
            cnt_reg      <= '0;
            if (go_iter) begin
              state_reg <= ST_ITER;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end else begin
              // Single-cycle responses: MFHI/MFLO, DIV by zero, no-ops.
              done_reg <= 1'b1;
              if (is_div) begin
                div_zero_reg <= 1'b1;
              end
              if (op == OP_MFHI) begin
                out_reg <= hi_reg;
              end
              if (op == OP_MFLO) begin
                out_reg <= lo_reg;
              end
            end
          end
        end
        ST_ITER: begin
          if (cnt_reg == CNT_W'(MUU_ITERS - 1)) begin
            state_reg <= ST_FIN;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FIN: begin
          case (op_reg)
            OP_MUL:  out_reg <= prod_signed[WIDTH-1:0];
            OP_MULT: {hi_reg, lo_reg} <= prod_signed;
            OP_MADD: {hi_reg, lo_reg} <= {hi_reg, lo_reg} + prod_signed;
            OP_DIV: begin
              lo_reg <= quot_signed;
              hi_reg <= rem_signed;
            end
            default: ;
          endcase
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign out      = out_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule
